// File: rtl/conv_pool_writeback_pkg.sv
// rtl/conv_pool_writeback_pkg.sv - shared parameters and FSM encoding for conv_pool_writeback
//
// Purpose: default geometry and width values for the writeback block, plus the
//          IDLE/RUN/DONE state encoding. No ports.
package conv_pool_writeback_pkg;

  localparam int CPW_DATA_WIDTH             = 16;
  localparam int CPW_ACC_WIDTH              = 32;
  localparam int CPW_FRAC_SHIFT             = 8;
  localparam int CPW_OUT_FEATURE_WIDTH      = 8;
  localparam int CPW_OUT_FEATURE_WIDTH_POOL = CPW_OUT_FEATURE_WIDTH / 2;
  localparam int CPW_NUM_MAPS               = 4;
  localparam int CPW_OUT_ADDR_WIDTH         = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/conv_pool_writeback_requant_relu_sat.sv
// rtl/conv_pool_writeback_requant_relu_sat.sv - accumulator requantise, ReLU and saturate
//
// Purpose: combinational arithmetic shift of the MAC accumulator, clamp negatives
//          to zero, saturate to the largest positive DATA_WIDTH value.
// Ports:
//   acc  in  ACC_WIDTH   signed accumulator result
//   q    out DATA_WIDTH  requantised non-negative pixel
module requant_relu_sat #(
  parameter int ACC_WIDTH  = 32,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_SHIFT = 8
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic        [DATA_WIDTH-1:0] q
);

  localparam logic signed [ACC_WIDTH-1:0] MAX_Q =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};

  logic signed [ACC_WIDTH-1:0] shifted;

  assign shifted = acc >>> FRAC_SHIFT;

  always_comb begin
    q = shifted[DATA_WIDTH-1:0];
    if (shifted[ACC_WIDTH-1]) begin
      q = '0;
    end else if (shifted > MAX_Q) begin
      q = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/conv_pool_writeback.sv
// rtl/conv_pool_writeback.sv - requantise, ReLU, 2x2 max-pool and write conv output maps
//
// Purpose: takes one accumulated pixel per accum_sload (raster order, map after
//          map), requantises it, max-pools 2x2/stride 2 and writes pooled pixels
//          to the output memory. pool_done is sticky after the last map.
// Ports:
//   clock, reset      clock and asynchronous active-high reset
//   enable            arms the block (IDLE->RUN)
//   accum_sload       one-cycle pulse, accum_result valid
//   accum_result      signed accumulated conv pixel
//   out_wren          one-cycle write strobe to output memory
//   out_addr/out_data write address and pooled pixel (hold between writes)
//   pool_done         sticky, all maps written
//   overrun           sticky, accum_sload seen while not accepting pixels
module conv_pool_writeback
  import conv_pool_writeback_pkg::*;
#(
  parameter int DATA_WIDTH             = CPW_DATA_WIDTH,
  parameter int ACC_WIDTH              = CPW_ACC_WIDTH,
  parameter int FRAC_SHIFT             = CPW_FRAC_SHIFT,
  parameter int OUT_FEATURE_WIDTH      = CPW_OUT_FEATURE_WIDTH,
  parameter int OUT_FEATURE_WIDTH_POOL = CPW_OUT_FEATURE_WIDTH_POOL,
  parameter int NUM_MAPS               = CPW_NUM_MAPS,
  parameter int OUT_ADDR_WIDTH         = CPW_OUT_ADDR_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      accum_sload,
  input  logic [ACC_WIDTH-1:0]      accum_result,
  output logic                      out_wren,
  output logic [OUT_ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      pool_done,
  output logic                      overrun
);

  localparam int COL_W = $clog2(OUT_FEATURE_WIDTH);
  localparam int MAP_W = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;

  function automatic logic [DATA_WIDTH-1:0] max2(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t state;

  // Input-side position counters
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] row;
  logic [MAP_W-1:0] map;
  // Set once the final pixel of the run is taken; later pulses are overruns
  logic             last_in;

  // Stage 1 registers
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_q;
  logic [COL_W-1:0]      s1_col;
  logic [COL_W-1:0]      s1_row;
  logic [MAP_W-1:0]      s1_map;
  logic                  s1_last;

  // Stage 2 state
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  s2_last;
  logic [DATA_WIDTH-1:0] linebuf [OUT_FEATURE_WIDTH_POOL];

  logic [DATA_WIDTH-1:0]     q_c;
  logic [OUT_ADDR_WIDTH-1:0] addr_c;
  logic                      accept;
  logic                      col_last;
  logic                      row_last;
  logic                      map_last;

  requant_relu_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_SHIFT(FRAC_SHIFT)
  ) u_requant (
    .acc(accum_result),
    .q  (q_c)
  );

  assign accept   = accum_sload && (state == ST_RUN) && !last_in;
  assign col_last = (col == COL_W'(OUT_FEATURE_WIDTH - 1));
  assign row_last = (row == COL_W'(OUT_FEATURE_WIDTH - 1));
  assign map_last = (map == MAP_W'(NUM_MAPS - 1));

  assign addr_c = OUT_ADDR_WIDTH'(s1_map) *
                    OUT_ADDR_WIDTH'(OUT_FEATURE_WIDTH_POOL * OUT_FEATURE_WIDTH_POOL)
                + OUT_ADDR_WIDTH'(s1_row >> 1) * OUT_ADDR_WIDTH'(OUT_FEATURE_WIDTH_POOL)
                + OUT_ADDR_WIDTH'(s1_col >> 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      col       <= '0;
      row       <= '0;
      map       <= '0;
      last_in   <= 1'b0;
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      s1_col    <= '0;
      s1_row    <= '0;
      s1_map    <= '0;
      s1_last   <= 1'b0;
      hold_q    <= '0;
      s2_last   <= 1'b0;
      out_wren  <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      pool_done <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_wren <= 1'b0;
      s1_valid <= accept;
      s2_last  <= s1_valid && s1_last;

      case (state)
        ST_IDLE: if (enable) state <= ST_RUN;
        ST_RUN: begin
          // s2_last is high the cycle the final write is on the outputs
          if (s2_last) begin
            state     <= ST_DONE;
            pool_done <= 1'b1;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase

      if (accum_sload && !accept) overrun <= 1'b1;

      // Stage 1: capture the requantised pixel with its position, then advance
      if (accept) begin
        s1_q    <= q_c;
        s1_col  <= col;
        s1_row  <= row;
        s1_map  <= map;
        s1_last <= col_last && row_last && map_last;
        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row <= '0;
            if (map_last) begin
              map     <= '0;
              last_in <= 1'b1;
            end else begin
              map <= map + 1'b1;
            end
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end

      // Stage 2: pooling by (row parity, col parity); the even-row/odd-col case
      // only updates the line buffer, handled in the block below.
      if (s1_valid) begin
        case ({s1_row[0], s1_col[0]})
          2'b00: hold_q <= s1_q;
          2'b10: hold_q <= max2(linebuf[s1_col[COL_W-1:1]], s1_q);
          2'b11: begin
            out_wren <= 1'b1;
            out_data <= max2(hold_q, s1_q);
            out_addr <= addr_c;
          end
          default: ;
        endcase
      end
    end
  end

  // Line buffer holds the top-row pair max for each pooled column; contents
  // are don't-care after reset, so it carries no reset.
  always_ff @(posedge clock) begin
    if (s1_valid && !s1_row[0] && s1_col[0]) begin
      linebuf[s1_col[COL_W-1:1]] <= max2(hold_q, s1_q);
    end
  end

endmodule
